// File: rtl/execute_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module  : execute_cycle_pkg
// Brief   : Shared encodings for the EX stage (ALU ops, forward selects,
//           result source selects).
// Revision: 1.0 - initial release
// ============================================================================
package execute_cycle_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Operand forward selects; 2'b11 is reserved and behaves as FWD_RF
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Writeback result source selects
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

endpackage : execute_cycle_pkg
`default_nettype wire

// File: rtl/execute_cycle_alu.sv
`default_nettype none
// ============================================================================
// Module  : execute_cycle_alu
// Brief   : Combinational RV32I ALU (add, sub, and, or, signed slt) with zero.
// Revision: 1.0 - initial release
// ============================================================================
module execute_cycle_alu
    import execute_cycle_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic [XLEN_P-1:0] SrcA,
    input  logic [XLEN_P-1:0] SrcB,
    input  logic [2:0]        ALUControl,
    output logic [XLEN_P-1:0] Result,
    output logic              Zero
);

    logic [XLEN_P-1:0] w_diff;
    logic              w_overflow;
    logic              w_less;

    assign w_diff     = SrcA - SrcB;
    // Subtraction overflows when operand signs differ and the result sign
    // disagrees with A; the true signed "less than" is the sign xor overflow.
    assign w_overflow = (SrcA[XLEN_P-1] ^ SrcB[XLEN_P-1]) & (w_diff[XLEN_P-1] ^ SrcA[XLEN_P-1]);
    assign w_less     = w_diff[XLEN_P-1] ^ w_overflow;

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = w_diff;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN_P-1){1'b0}}, w_less};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule : execute_cycle_alu
`default_nettype wire

// File: rtl/execute_cycle.sv
`default_nettype none
// ============================================================================
// Module  : execute_cycle
// Brief   : RV32I EX stage: operand forwarding, ALU, branch/jump resolution
//           and the EX/MEM pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
module execute_cycle
    import execute_cycle_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteE,
    input  logic               ALUSrcE,
    input  logic               MemWriteE,
    input  logic [1:0]         ResultSrcE,
    input  logic               BranchE,
    input  logic               JumpE,
    input  logic [2:0]         ALUControlE,
    input  logic [XLEN-1:0]    RD1_E,
    input  logic [XLEN-1:0]    RD2_E,
    input  logic [XLEN-1:0]    Imm_Ext_E,
    input  logic [RADDR_W-1:0] RD_E,
    input  logic [XLEN-1:0]    PCE,
    input  logic [XLEN-1:0]    PCPlus4E,
    input  logic [XLEN-1:0]    ResultW,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    output logic               PCSrcE,
    output logic [XLEN-1:0]    PCTargetE,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic [1:0]         ResultSrcM,
    output logic [RADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]    ALUResultM,
    output logic [XLEN-1:0]    WriteDataM,
    output logic [XLEN-1:0]    PCPlus4M
);

    logic [XLEN-1:0]    w_srcA;
    logic [XLEN-1:0]    w_writeDataE;
    logic [XLEN-1:0]    w_srcB;
    logic [XLEN-1:0]    w_aluResultE;
    logic               w_zeroE;

    logic               r_regWriteM;
    logic               r_memWriteM;
    logic [1:0]         r_resultSrcM;
    logic [RADDR_W-1:0] r_rdM;
    logic [XLEN-1:0]    r_aluResultM;
    logic [XLEN-1:0]    r_writeDataM;
    logic [XLEN-1:0]    r_pcPlus4M;

    // Forward muxes; the reserved select falls back to the register file value
    always_comb begin
        w_srcA = RD1_E;
        case (ForwardAE)
            FWD_WB:  w_srcA = ResultW;
            FWD_MEM: w_srcA = r_aluResultM;
            default: w_srcA = RD1_E;
        endcase
    end

    always_comb begin
        w_writeDataE = RD2_E;
        case (ForwardBE)
            FWD_WB:  w_writeDataE = ResultW;
            FWD_MEM: w_writeDataE = r_aluResultM;
            default: w_writeDataE = RD2_E;
        endcase
    end

    assign w_srcB = ALUSrcE ? Imm_Ext_E : w_writeDataE;

    execute_cycle_alu #(
        .XLEN_P     (XLEN)
    ) u_alu (
        .SrcA       (w_srcA),
        .SrcB       (w_srcB),
        .ALUControl (ALUControlE),
        .Result     (w_aluResultE),
        .Zero       (w_zeroE)
    );

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = (BranchE & w_zeroE) | JumpE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regWriteM  <= 1'b0;
            r_memWriteM  <= 1'b0;
            r_resultSrcM <= 2'b00;
            r_rdM        <= '0;
            r_aluResultM <= '0;
            r_writeDataM <= '0;
            r_pcPlus4M   <= '0;
        end else begin
            r_regWriteM  <= RegWriteE;
            r_memWriteM  <= MemWriteE;
            r_resultSrcM <= ResultSrcE;
            r_rdM        <= RD_E;
            r_aluResultM <= w_aluResultE;
            r_writeDataM <= w_writeDataE;
            r_pcPlus4M   <= PCPlus4E;
        end
    end

    assign RegWriteM  = r_regWriteM;
    assign MemWriteM  = r_memWriteM;
    assign ResultSrcM = r_resultSrcM;
    assign RD_M       = r_rdM;
    assign ALUResultM = r_aluResultM;
    assign WriteDataM = r_writeDataM;
    assign PCPlus4M   = r_pcPlus4M;

endmodule : execute_cycle
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// ============================================================================
// Module  : tb_execute_cycle
// Brief   : Table-driven self-checking bench for the EX stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int nCmp  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .JumpE       (JumpE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .RD_E        (RD_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ResultW     (ResultW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M)
    );

    typedef struct {
        logic        regWrite;
        logic        aluSrc;
        logic        memWrite;
        logic [1:0]  resultSrc;
        logic        branch;
        logic        jump;
        logic [2:0]  aluCtl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] resultW;
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
        logic        xPcSrc;
        logic [31:0] xTarget;
        logic [31:0] xAlu;
        logic [31:0] xWd;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        RegWriteE   = v.regWrite;
        ALUSrcE     = v.aluSrc;
        MemWriteE   = v.memWrite;
        ResultSrcE  = v.resultSrc;
        BranchE     = v.branch;
        JumpE       = v.jump;
        ALUControlE = v.aluCtl;
        RD1_E       = v.rd1;
        RD2_E       = v.rd2;
        Imm_Ext_E   = v.imm;
        RD_E        = v.rd;
        PCE         = v.pc;
        PCPlus4E    = v.pcp4;
        ResultW     = v.resultW;
        ForwardAE   = v.fwdA;
        ForwardBE   = v.fwdB;
    endtask

    task automatic checkM(input string tag, input vec_t v, input logic zeroed);
        if (zeroed) begin
            chk({tag, ".RegWriteM"},  {31'd0, RegWriteM},  32'd0);
            chk({tag, ".MemWriteM"},  {31'd0, MemWriteM},  32'd0);
            chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, 32'd0);
            chk({tag, ".RD_M"},       {27'd0, RD_M},       32'd0);
            chk({tag, ".ALUResultM"}, ALUResultM,          32'd0);
            chk({tag, ".WriteDataM"}, WriteDataM,          32'd0);
            chk({tag, ".PCPlus4M"},   PCPlus4M,            32'd0);
        end else begin
            chk({tag, ".RegWriteM"},  {31'd0, RegWriteM},  {31'd0, v.regWrite});
            chk({tag, ".MemWriteM"},  {31'd0, MemWriteM},  {31'd0, v.memWrite});
            chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, v.resultSrc});
            chk({tag, ".RD_M"},       {27'd0, RD_M},       {27'd0, v.rd});
            chk({tag, ".ALUResultM"}, ALUResultM,          v.xAlu);
            chk({tag, ".WriteDataM"}, WriteDataM,          v.xWd);
            chk({tag, ".PCPlus4M"},   PCPlus4M,            v.pcp4);
        end
    endtask

    // Drive on the falling edge, check combinational outputs 1ns later,
    // then check the EX/MEM register 1ns after the rising edge.
    task automatic applyVec(input string tag, input vec_t v, input logic doReset);
        @(negedge clk);
        rst = doReset;
        drive(v);
        #1;
        chk({tag, ".PCSrcE"},    {31'd0, PCSrcE}, {31'd0, v.xPcSrc});
        chk({tag, ".PCTargetE"}, PCTargetE,       v.xTarget);
        @(posedge clk);
        #1;
        checkM(tag, v, doReset);
    endtask

    initial begin
        //             rW aS mW rSrc  br jp ctl     rd1           rd2           imm           rd    pc            pcp4          resW     fA     fB     xPS  xTarget       xAlu          xWd
        vecs[0]  = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,32'd4,        32'd5,        32'd0,        5'd3, 32'h100,      32'h104,      32'd0,   2'b00,2'b00, 1'b0,32'h100,     32'd9,        32'd5};
        vecs[1]  = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,32'd1,        32'h77,       32'd0,        5'd4, 32'h0,        32'h4,        32'd5,   2'b10,2'b01, 1'b0,32'h0,       32'd14,       32'd5};
        vecs[2]  = '{1'b0,1'b1,1'b1,2'b00,1'b0,1'b0,3'b000,32'h100,      32'hAB,       32'h10,       5'd0, 32'h200,      32'h204,      32'd0,   2'b00,2'b00, 1'b0,32'h210,     32'h110,      32'hAB};
        vecs[3]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,3'b001,32'd7,        32'd7,        32'hFFFFFFF8, 5'd0, 32'h40,       32'h44,       32'd0,   2'b00,2'b00, 1'b1,32'h38,      32'd0,        32'd7};
        vecs[4]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,3'b001,32'd7,        32'd6,        32'hFFFFFFF8, 5'd0, 32'h40,       32'h44,       32'd0,   2'b00,2'b00, 1'b0,32'h38,      32'd1,        32'd6};
        vecs[5]  = '{1'b1,1'b0,1'b0,2'b10,1'b0,1'b1,3'b000,32'd0,        32'd0,        32'h100,      5'd1, 32'h20,       32'h24,       32'd0,   2'b00,2'b00, 1'b1,32'h120,     32'd0,        32'd0};
        vecs[6]  = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b101,32'h80000000, 32'd1,        32'd0,        5'd2, 32'h0,        32'h4,        32'd0,   2'b00,2'b00, 1'b0,32'h0,       32'd1,        32'd1};
        vecs[7]  = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b101,32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0,        5'd2, 32'h0,        32'h4,        32'd0,   2'b00,2'b00, 1'b0,32'h0,       32'd0,        32'hFFFFFFFF};
        vecs[8]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,3'b111,32'd5,        32'd3,        32'd4,        5'd0, 32'h10,       32'h14,       32'd0,   2'b00,2'b00, 1'b1,32'h14,      32'd0,        32'd3};
        vecs[9]  = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b010,32'hF0F0,     32'hFF00,     32'd0,        5'd5, 32'h0,        32'h4,        32'd0,   2'b00,2'b00, 1'b0,32'h0,       32'hF000,     32'hFF00};
        vecs[10] = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b011,32'hF0F0,     32'h0F0F,     32'd0,        5'd5, 32'h0,        32'h4,        32'd0,   2'b00,2'b00, 1'b0,32'h0,       32'hFFFF,     32'h0F0F};
        vecs[11] = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,32'd2,        32'h55,       32'd0,        5'd6, 32'h0,        32'h4,        32'd100, 2'b11,2'b10, 1'b0,32'h0,       32'h10001,    32'hFFFF};
        vecs[12] = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,32'hFFFFFFFF, 32'd2,        32'h20,       5'd7, 32'hFFFFFFF0, 32'hFFFFFFF4, 32'd0,   2'b00,2'b00, 1'b0,32'h10,      32'd1,        32'd2};
        vecs[13] = '{1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,3'b100,32'd5,        32'd9,        32'd3,        5'd0, 32'h0,        32'h4,        32'd0,   2'b00,2'b00, 1'b0,32'h3,       32'd0,        32'd9};
        vecs[14] = '{1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,32'd0,        32'd0,        32'd0,        5'd0, 32'h0,        32'h0,        32'd0,   2'b00,2'b00, 1'b0,32'h0,       32'd0,        32'd0};
        vecs[15] = '{1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,3'b001,32'd3,        32'h99,       32'd0,        5'd0, 32'h0,        32'h4,        32'd5,   2'b00,2'b01, 1'b0,32'h0,       32'hFFFFFFFE, 32'd5};
        vecs[16] = '{1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,32'd1,        32'd2,        32'd0,        5'd9, 32'h0,        32'h4,        32'h20,  2'b01,2'b11, 1'b0,32'h0,       32'h22,       32'd2};

        rst = 1'b1;
        drive(vecs[14]);

        // Reset with nonzero ID/EX, then release and see the same bundle load
        applyVec("reset", vecs[0], 1'b1);
        applyVec("post_reset", vecs[0], 1'b0);

        for (int i = 0; i < NVEC; i++)
            applyVec($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Reset asserted during a jump clears EX/MEM; the jump then loads
        applyVec("reset_mid_jump", vecs[5], 1'b1);
        applyVec("jump_after_reset", vecs[5], 1'b0);

        // Forward from ALUResultM after a reset sees zero
        applyVec("reset_again", vecs[9], 1'b1);
        begin
            vec_t v;
            v = vecs[1];
            v.xAlu = 32'd5;
            applyVec("fwd_mem_after_reset", v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
        $finish;
    end

endmodule : tb_execute_cycle
`default_nettype wire
